pump_ctrl: RTL and testbench
============================

PUMP_CTRL -- requirements
Module: pump_ctrl

Interface
REQ-001 SHALL provide parameter DEBOUNCE, default 4, meaning consecutive identical samples required to accept a level.
REQ-002 SHALL provide parameter MAX_FILL, default 1000, meaning maximum FILLING cycles before timeout fault.
REQ-003 SHALL provide parameter MIN_OFF, default 16, meaning minimum pump-off cycles in COOLDOWN.
REQ-004 SHALL have port clk  input  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have ports full, half, empty  input  1 each  registered tank-level flags from the level-indicator stage.
REQ-007 SHALL have port manual_off  input  1  operator stop request, level-sensitive.
REQ-008 SHALL have port fault_clr  input  1  single-cycle fault acknowledge.
REQ-009 SHALL have port pump_on  output  1  pump motor enable.
REQ-010 SHALL have port level  output  2  debounced level: 00 unknown, 01 empty, 10 half, 11 full.
REQ-011 SHALL have port state  output  2  FSM state: 00 IDLE, 01 FILLING, 10 COOLDOWN, 11 FAULT.
REQ-012 SHALL have port fault  output  1  high while in FAULT.

Function
REQ-013 SHALL register {full,half,empty} once per clk; a stability counter counts consecutive cycles with an unchanged sampled vector, saturating at DEBOUNCE.
REQ-014 SHALL update level on the cycle the counter reaches DEBOUNCE with a one-hot vector; latency from input change to level change = DEBOUNCE+1 cycles.
REQ-015 SHALL hold level unchanged for an all-zero vector, however long it persists.
REQ-016 SHALL raise internal sensor_err for one cycle when a multi-hot vector reaches DEBOUNCE stability; level unchanged.
REQ-017 IDLE: pump off; go FILLING when level==01 and manual_off==0.
REQ-018 FILLING: fill counter increments each cycle; go COOLDOWN when level==11 or manual_off==1; go FAULT when counter==MAX_FILL-1 without level==11.
REQ-019 FILLING: first transition of level to 10 clears the fill counter once per fill (progress watchdog reload).
REQ-020 COOLDOWN: pump off; off counter runs MIN_OFF cycles, then IDLE regardless of level.
REQ-021 FAULT: pump off; stay until fault_clr==1, then COOLDOWN.
REQ-022 sensor_err SHALL force FAULT from IDLE, FILLING, COOLDOWN; ignored in FAULT.
REQ-023 Priority in FILLING same cycle: sensor_err > level==11 / manual_off > timeout.
REQ-024 pump_on SHALL equal (state==FILLING), decoded from the registered state; fault SHALL equal (state==FAULT).
REQ-025 fill and off counters SHALL clear on every state entry; widths sized by $clog2 of their parameter, no wrap.
REQ-026 fault_clr outside FAULT SHALL be ignored.

Reset
REQ-027 On rst: state IDLE, level 00, pump_on 0, fault 0, sample register 0, all counters 0, taking effect at the next clk edge.
REQ-028 Reset asserted mid-FILLING SHALL drop pump_on the cycle after the sampling edge; no COOLDOWN is enforced after reset.

Structure
REQ-029 Shared package pump_pkg SHALL hold state encodings and level codes.
REQ-030 Debounce logic (REQ-013..016) SHALL be sub-module level_debounce; FSM and counters in pump_ctrl.

Verification (DEBOUNCE=4, MAX_FILL=20, MIN_OFF=8)
REQ-031 empty=1 held from cycle 0 after reset -> level=01 at cycle 5, pump_on=1 at cycle 6.
REQ-032 In FILLING, full=1 held -> level=11 after 5 cycles, pump_on=0 next cycle, state=10 for 8 cycles then 00.
REQ-033 In FILLING, no full/half for 20 cycles -> state=11, fault=1, pump_on=0; fault_clr pulse -> state=10 next cycle.
REQ-034 empty glitch of 3 cycles -> level unchanged, pump stays off.
REQ-035 full=half=1 held 5 cycles during FILLING -> FAULT; level retains prior value.
REQ-036 rst pulsed mid-FILLING -> pump_on=0, state=00, level=00 the following cycle.

Source files
------------

// File: rtl/pump_pkg.sv
// Shared encodings for the pump controller: FSM states, debounced level codes
// and the mapping from the raw {full,half,empty} flag vector to a level.
package pump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_FILLING  = 2'b01,
    ST_COOLDOWN = 2'b10,
    ST_FAULT    = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    LVL_UNKNOWN = 2'b00,
    LVL_EMPTY   = 2'b01,
    LVL_HALF    = 2'b10,
    LVL_FULL    = 2'b11
  } level_e;

  // Vector order is {full, half, empty}; anything not one-hot maps to unknown.
  function automatic level_e vec2level(input logic [2:0] v);
    level_e l;
    case (v)
      3'b001:  l = LVL_EMPTY;
      3'b010:  l = LVL_HALF;
      3'b100:  l = LVL_FULL;
      default: l = LVL_UNKNOWN;
    endcase
    return l;
  endfunction

  function automatic logic multi_hot(input logic [2:0] v);
    return (v & (v - 3'd1)) != 3'd0;
  endfunction

endpackage

// File: rtl/level_debounce.sv
// Samples the tank flags, requires DEBOUNCE repeats of the same vector, then
// publishes a one-hot vector as level or flags a multi-hot vector as an error.
module level_debounce
  import pump_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] vec_i,
  output level_e     level_o,
  output logic       sensor_err_o
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

  logic [2:0]    samp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  level_e        level_q;
  logic          err_q;
  logic          reach;

  always_comb begin
    cnt_d = '0;
    if (vec_i == samp_q) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  // Fires once per stable run: the edge the counter saturates, never again.
  assign reach = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q  <= '0;
      cnt_q   <= '0;
      level_q <= LVL_UNKNOWN;
      err_q   <= 1'b0;
    end else begin
      samp_q <= vec_i;
      cnt_q  <= cnt_d;
      err_q  <= reach && multi_hot(vec_i);
      if (reach && vec2level(vec_i) != LVL_UNKNOWN) level_q <= vec2level(vec_i);
    end
  end

  assign level_o      = level_q;
  assign sensor_err_o = err_q;

endmodule

// File: rtl/pump_ctrl.sv
// Tank fill controller: debounced level drives an IDLE/FILLING/COOLDOWN/FAULT
// FSM with a fill watchdog and a minimum pump-off interval.
module pump_ctrl
  import pump_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int MAX_FILL = 1000,
  parameter int MIN_OFF  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       full,
  input  logic       half,
  input  logic       empty,
  input  logic       manual_off,
  input  logic       fault_clr,
  output logic       pump_on,
  output logic [1:0] level,
  output logic [1:0] state,
  output logic       fault
);

  localparam int FW = (MAX_FILL > 1) ? $clog2(MAX_FILL) : 1;
  localparam int OW = (MIN_OFF > 1) ? $clog2(MIN_OFF) : 1;
  localparam logic [FW-1:0] FILL_LAST = FW'(MAX_FILL - 1);
  localparam logic [OW-1:0] OFF_LAST  = OW'(MIN_OFF - 1);

  level_e        lvl;
  logic          sensor_err;
  state_e        state_q, state_d;
  logic [FW-1:0] fill_q;
  logic [OW-1:0] off_q;
  logic          half_seen_q;

  level_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
    .clk          (clk),
    .rst          (rst),
    .vec_i        ({full, half, empty}),
    .level_o      (lvl),
    .sensor_err_o (sensor_err)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (sensor_err)                             state_d = ST_FAULT;
        else if (lvl == LVL_EMPTY && !manual_off)   state_d = ST_FILLING;
      ST_FILLING:
        if (sensor_err)                             state_d = ST_FAULT;
        else if (lvl == LVL_FULL || manual_off)     state_d = ST_COOLDOWN;
        else if (fill_q == FILL_LAST)               state_d = ST_FAULT;
      ST_COOLDOWN:
        if (sensor_err)                             state_d = ST_FAULT;
        else if (off_q == OFF_LAST)                 state_d = ST_IDLE;
      default:
        if (fault_clr)                              state_d = ST_COOLDOWN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fill_q      <= '0;
      off_q       <= '0;
      half_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        fill_q      <= '0;
        off_q       <= '0;
        half_seen_q <= 1'b0;
      end else if (state_q == ST_FILLING) begin
        // Reaching half-full proves progress: reload the watchdog once per fill.
        if (lvl == LVL_HALF && !half_seen_q) begin
          fill_q      <= '0;
          half_seen_q <= 1'b1;
        end else begin
          fill_q <= fill_q + 1'b1;
        end
      end else if (state_q == ST_COOLDOWN) begin
        off_q <= off_q + 1'b1;
      end
    end
  end

  assign state   = state_q;
  assign level   = lvl;
  assign pump_on = (state_q == ST_FILLING);
  assign fault   = (state_q == ST_FAULT);

endmodule

// File: tb/tb_pump_ctrl.sv
// Directed scenarios with literal expectations, then randomized flags checked
// every cycle against a timestamp-based behavioural model of the controller.
module tb_pump_ctrl;

  localparam int DEB = 4;
  localparam int MF  = 20;
  localparam int MO  = 8;

  logic       clk, rst, full, half, empty, manual_off, fault_clr;
  logic       pump_on, fault;
  logic [1:0] level, state;

  int errors = 0;
  int checks = 0;

  pump_ctrl #(.DEBOUNCE(DEB), .MAX_FILL(MF), .MIN_OFF(MO)) dut (
    .clk(clk), .rst(rst), .full(full), .half(half), .empty(empty),
    .manual_off(manual_off), .fault_clr(fault_clr),
    .pump_on(pump_on), .level(level), .state(state), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state codes 0..3, level codes 0..3; timers are edge timestamps.
  int         m_state, m_level, m_run, cyc, t_start, m_lv;
  bit         m_err, m_half, m_er, chk_en;
  logic [2:0] m_prev, m_v;

  task automatic go(input int s);
    m_state = s;
    t_start = cyc;
    m_half  = 1'b0;
  endtask

  initial begin
    cyc = 0; chk_en = 1'b0;
    forever begin
      @(posedge clk);
      m_v = {full, half, empty};
      m_lv = m_level;
      m_er = m_err;
      cyc++;
      if (rst) begin
        m_state = 0; m_level = 0; m_err = 1'b0; m_prev = 3'b000; m_run = 1;
        m_half = 1'b0; t_start = cyc; chk_en = 1'b1;
      end else begin
        case (m_state)
          0: if (m_er) go(3);
             else if (m_lv == 1 && !manual_off) go(1);
          1: if (m_er) go(3);
             else if (m_lv == 3 || manual_off) go(2);
             else if (cyc - t_start == MF) go(3);
             else if (m_lv == 2 && !m_half) begin t_start = cyc; m_half = 1'b1; end
          2: if (m_er) go(3);
             else if (cyc - t_start == MO) go(0);
          default: if (fault_clr) go(2);
        endcase
        // A vector takes effect on the edge it has been seen DEB+1 times in a row.
        if (m_v == m_prev) begin
          if (m_run <= DEB + 1) m_run++;
        end else begin
          m_prev = m_v;
          m_run  = 1;
        end
        m_err = 1'b0;
        if (m_run == DEB + 1) begin
          if ($countones(m_v) == 1) m_level = (m_v == 3'b001) ? 1 : (m_v == 3'b010) ? 2 : 3;
          else if ($countones(m_v) > 1) m_err = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cmp_state", state, m_state);
        chk("cmp_level", level, m_level);
        chk("cmp_pump", pump_on, m_state == 1);
        chk("cmp_fault", fault, m_state == 3);
      end
    end
  end

  initial begin
    logic [2:0] vec;
    int hold;
    rst = 1'b1; {full, half, empty} = 3'b000; manual_off = 1'b0; fault_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", state, 0); chk("rst_level", level, 0);
    chk("rst_pump", pump_on, 0); chk("rst_fault", fault, 0);
    rst = 1'b0;

    // Empty held: level after DEB+1 edges, pump one edge later.
    empty = 1'b1;
    repeat (4) @(negedge clk);
    chk("deb_level_early", level, 0);
    @(negedge clk);
    chk("deb_level", level, 1); chk("deb_pump_off", pump_on, 0); chk("model_level", m_level, 1);
    @(negedge clk);
    chk("fill_pump", pump_on, 1); chk("fill_state", state, 1); chk("model_state", m_state, 1);

    // No progress: watchdog fault after MF filling cycles.
    repeat (19) @(negedge clk);
    chk("wd_not_yet", state, 1);
    @(negedge clk);
    chk("wd_state", state, 3); chk("wd_fault", fault, 1); chk("wd_pump", pump_on, 0);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("clr_state", state, 2);
    repeat (7) @(negedge clk);
    chk("cool_hold", state, 2);
    @(negedge clk);
    chk("cool_done", state, 0);
    @(negedge clk);
    chk("refill", state, 1);

    // Full while filling: level, then COOLDOWN for MO cycles.
    full = 1'b1; empty = 1'b0;
    repeat (4) @(negedge clk);
    chk("full_level_early", level, 1);
    @(negedge clk);
    chk("full_level", level, 3); chk("full_pump_still", pump_on, 1);
    @(negedge clk);
    chk("full_pump_off", pump_on, 0); chk("full_cool", state, 2);
    repeat (7) @(negedge clk);
    chk("full_cool_hold", state, 2);
    @(negedge clk);
    chk("full_idle", state, 0);

    // Short empty glitch must not change level.
    full = 1'b0; empty = 1'b1;
    repeat (3) @(negedge clk);
    full = 1'b1; empty = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("glitch_level", level, 3); chk("glitch_pump", pump_on, 0);
    end

    // Multi-hot during FILLING forces FAULT, level retained.
    full = 1'b0; empty = 1'b1;
    repeat (6) @(negedge clk);
    chk("mh_filling", state, 1);
    full = 1'b1; half = 1'b1; empty = 1'b0;
    repeat (5) @(negedge clk);
    chk("mh_not_yet", state, 1);
    @(negedge clk);
    chk("mh_fault", state, 3); chk("mh_level", level, 1);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    full = 1'b0; half = 1'b0; empty = 1'b1;

    // Reset mid-FILLING.
    for (int i = 0; i < 40 && state != 2'b01; i++) @(negedge clk);
    chk("reach_fill", state, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstfill_pump", pump_on, 0); chk("rstfill_state", state, 0); chk("rstfill_level", level, 0);

    // Random phase.
    hold = 0; vec = 3'b001;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2: vec = 3'b001;
          3, 4:    vec = 3'b010;
          5, 6:    vec = 3'b100;
          7:       vec = 3'b000;
          8:       vec = 3'b110;
          default: vec = ($urandom_range(0, 1) == 0) ? 3'b011 : 3'b111;
        endcase
        hold = $urandom_range(1, 14);
      end
      hold--;
      {full, half, empty} = vec;
      if ($urandom_range(0, 29) == 0) manual_off = ~manual_off;
      fault_clr = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
